// File: rtl/asc_hex_word_assembler.sv
// ASCII hex text to binary word assembler: classifies each accepted byte,
// packs hex digits MSB-first and hands finished words out on a valid/ready port.

module asc_hex_to_nybble #(
  parameter int METHOD = 0
) (
  input  logic [7:0] ascii,
  output logic [3:0] nybble,
  output logic       is_hex
);

  assign is_hex = ((ascii >= 8'h30) && (ascii <= 8'h39)) ||
                  ((ascii >= 8'h41) && (ascii <= 8'h46)) ||
                  ((ascii >= 8'h61) && (ascii <= 8'h66));

  generate
    if (METHOD == 1) begin : g_arith
      // Letters have bit 6 set and low nybble 1..6, so adding 9 yields A..F.
      assign nybble = ascii[3:0] + (ascii[6] ? 4'd9 : 4'd0);
    end else begin : g_table
      always_comb begin
        nybble = 4'h0;
        case (ascii)
          8'h30: nybble = 4'h0;
          8'h31: nybble = 4'h1;
          8'h32: nybble = 4'h2;
          8'h33: nybble = 4'h3;
          8'h34: nybble = 4'h4;
          8'h35: nybble = 4'h5;
          8'h36: nybble = 4'h6;
          8'h37: nybble = 4'h7;
          8'h38: nybble = 4'h8;
          8'h39: nybble = 4'h9;
          8'h41, 8'h61: nybble = 4'hA;
          8'h42, 8'h62: nybble = 4'hB;
          8'h43, 8'h63: nybble = 4'hC;
          8'h44, 8'h64: nybble = 4'hD;
          8'h45, 8'h65: nybble = 4'hE;
          8'h46, 8'h66: nybble = 4'hF;
          default:      nybble = 4'h0;
        endcase
      end
    end
  endgenerate

endmodule

module asc_hex_word_assembler #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic [3:0]            out_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, SKIP} state_t;

  state_t         state_reg;
  logic [W-1:0]   acc_reg;
  logic [3:0]     cnt_reg;
  logic [W-1:0]   out_word_reg;
  logic [3:0]     out_len_reg;
  logic           out_valid_reg;
  logic           out_err_reg;

  logic [3:0]     nybble;
  logic           is_hex;
  logic           is_delim;
  logic           accept;
  logic [W-1:0]   acc_next;
  logic [3:0]     cnt_next;
  logic           full;

  asc_hex_to_nybble #(.METHOD(1)) u_nybble (
    .ascii  (in_byte),
    .nybble (nybble),
    .is_hex (is_hex)
  );

  assign is_delim = (in_byte == 8'h20) || (in_byte == 8'h2C) ||
                    (in_byte == 8'h0D) || (in_byte == 8'h0A);

  assign in_ready = (state_reg != EMIT) && !rst;
  assign accept   = in_valid && in_ready;

  generate
    if (DIGITS == 1) begin : g_single
      assign acc_next = W'(nybble);
    end else begin : g_multi
      assign acc_next = {acc_reg[W-5:0], nybble};
    end
  endgenerate

  assign cnt_next = cnt_reg + 4'd1;
  assign full     = (cnt_next == 4'(DIGITS));

  // acc_reg and cnt_reg are always zero in IDLE, so the first digit can use
  // the same shift-and-count path as later digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_word_reg  <= '0;
      out_len_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      out_err_reg <= 1'b0;
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            if (is_hex) begin
              acc_reg <= acc_next;
              cnt_reg <= cnt_next;
              if (full) begin
                state_reg     <= EMIT;
                out_valid_reg <= 1'b1;
                out_word_reg  <= acc_next;
                out_len_reg   <= cnt_next;
              end else begin
                state_reg <= ACCUM;
              end
            end else if (is_delim) begin
              if (state_reg == ACCUM) begin
                state_reg     <= EMIT;
                out_valid_reg <= 1'b1;
                out_word_reg  <= acc_reg;
                out_len_reg   <= cnt_reg;
              end
            end else begin
              acc_reg     <= '0;
              cnt_reg     <= '0;
              out_err_reg <= 1'b1;
              state_reg   <= SKIP;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
            out_len_reg   <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
          end
        end
        SKIP: begin
          // Only a delimiter ends the bad token; out_err stays quiet meanwhile.
          if (accept && is_delim) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_word  = out_word_reg;
  assign out_len   = out_len_reg;
  assign out_valid = out_valid_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_asc_hex_word_assembler.sv
// Bench for asc_hex_word_assembler: token-level reference model checked every
// cycle, directed strings with literal expectations, then random traffic.

module tb_asc_hex_word_assembler;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid, in_ready;
  logic [31:0] out_word;
  logic [3:0]  out_len;
  logic        out_valid, out_ready, out_err;

  logic [7:0]  in1_byte;
  logic        in1_valid, in1_ready;
  logic [3:0]  out1_word;
  logic [3:0]  out1_len;
  logic        out1_valid, out1_ready, out1_err;

  always #5 clk = ~clk;

  asc_hex_word_assembler #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_len(out_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err)
  );

  asc_hex_word_assembler #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_byte(in1_byte), .in_valid(in1_valid),
    .in_ready(in1_ready), .out_word(out1_word), .out_len(out1_len),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_err(out1_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'd48 && b <= 8'd57)  return int'(b) - 48;
    if (b >= 8'd65 && b <= 8'd70)  return int'(b) - 55;
    if (b >= 8'd97 && b <= 8'd102) return int'(b) - 87;
    return -1;
  endfunction

  function automatic bit is_delim(input logic [7:0] b);
    return (b == 8'd32) || (b == 8'd44) || (b == 8'd13) || (b == 8'd10);
  endfunction

  // Reference model: a pending-word flag, a digit queue and a skip flag.
  bit          m_valid, m_err, m_skip, m_fresh, m_live;
  logic [31:0] m_word;
  logic [3:0]  m_len;
  int          m_dq[$];

  task automatic model_emit();
    logic [31:0] w;
    w = 32'd0;
    foreach (m_dq[i]) w = (w << 4) | 32'(m_dq[i]);
    m_word  = w;
    m_len   = 4'(m_dq.size());
    m_valid = 1'b1;
    m_fresh = 1'b0;
    m_dq.delete();
  endtask

  initial begin
    int hv;
    m_live = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b0; m_err = 1'b0; m_skip = 1'b0; m_fresh = 1'b1;
        m_word = 32'd0; m_len = 4'd0; m_dq.delete(); m_live = 1'b1;
      end else if (m_live) begin
        m_err = 1'b0;
        if (m_valid) begin
          if (out_ready) m_valid = 1'b0;
        end else if (in_valid) begin
          hv = hexval(in_byte);
          if (hv >= 0) begin
            if (!m_skip) begin
              m_dq.push_back(hv);
              if (m_dq.size() == D) model_emit();
            end
          end else if (is_delim(in_byte)) begin
            if (m_skip) m_skip = 1'b0;
            else if (m_dq.size() > 0) model_emit();
          end else if (!m_skip) begin
            m_err = 1'b1; m_skip = 1'b1; m_dq.delete();
          end
        end
      end
    end
  end

  logic [35:0] got[$];
  logic [7:0]  got1[$];
  int          err_seen = 0;

  // Per-cycle compare against the model, plus word capture.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("in_ready", in_ready, !m_valid && !rst);
        check("out_valid", out_valid, m_valid);
        check("out_err", out_err, m_err);
        if (m_valid || m_fresh) begin
          check("out_word", out_word, m_word);
          check("out_len", out_len, m_len);
        end
        if (out_valid && out_ready) begin
          got.push_back({out_len, out_word});
          $display("word %h len %0d", out_word, out_len);
        end
        if (out1_valid && out1_ready) begin
          got1.push_back({out1_len, out1_word});
          $display("word1 %h len %0d", out1_word, out1_len);
        end
        if (out_err) err_seen++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
    end
    if (!ok) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic check_words(input string tag, input int n,
                             input logic [35:0] e0, input logic [35:0] e1);
    check({tag, "_count"}, 64'(got.size()), 64'(n));
    if (n > 0) check({tag, "_w0"}, (got.size() > 0) ? got[0] : 36'hx, e0);
    if (n > 1) check({tag, "_w1"}, (got.size() > 1) ? got[1] : 36'hx, e1);
    got.delete();
  endtask

  function automatic logic [7:0] rand_byte();
    string hx, dl;
    int r;
    hx = "0123456789abcdefABCDEF";
    dl = " ,\r\n";
    r = $urandom_range(0, 9);
    if (r < 7)  return hx[$urandom_range(0, 21)];
    if (r < 9)  return dl[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    in1_valid = 1'b0; in1_byte = 8'h00; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_len", out_len, 4'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    settle();

    send_str("DEADbeef "); settle();
    check_words("t1", 1, {4'd8, 32'hDEADBEEF}, 36'h0);

    send_str("1A\n"); settle();
    check_words("t2", 1, {4'd2, 32'h0000001A}, 36'h0);

    err_seen = 0;
    send_str("12G4 5\n"); settle();
    check("t3_err_pulses", 64'(err_seen), 64'd1);
    check_words("t3", 1, {4'd1, 32'h00000005}, 36'h0);

    send_str("0123456789abcdef "); settle();
    check_words("t4", 2, {4'd8, 32'h01234567}, {4'd8, 32'h89ABCDEF});

    out_ready = 1'b0;
    send_str("CAFE ");
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t5_hold_valid", out_valid, 1'b1);
    check("t5_hold_word", out_word, 32'h0000CAFE);
    check("t5_hold_ready", in_ready, 1'b0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    settle();
    check_words("t5", 1, {4'd4, 32'h0000CAFE}, 36'h0);

    send_str("12");
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    send_str("3 "); settle();
    check_words("t6", 1, {4'd1, 32'h00000003}, 36'h0);

    for (int i = 0; i < 2; i++) begin
      bit ok;
      ok = 1'b0;
      in1_valid = 1'b1;
      in1_byte  = (i == 0) ? 8'h61 : 8'h62;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        ok = in1_ready;
        @(posedge clk);
        #2;
      end
      if (!ok) check("d1_send_timeout", 1'b0, 1'b1);
    end
    in1_valid = 1'b0;
    settle();
    check("d1_count", 64'(got1.size()), 64'd2);
    check("d1_w0", (got1.size() > 0) ? got1[0] : 8'hxx, {4'd1, 4'hA});
    check("d1_w1", (got1.size() > 1) ? got1[1] : 8'hxx, {4'd1, 4'hB});

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_byte   = rand_byte();
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #2;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
